trap_filter_ctrl: RTL and testbench

Sequencing and configuration controller for the trapezoidal shaping filter (`FilterV6` datapath: parameters k, l, m1, m2). Software programs the shaping parameters through a one-cycle write port. The block then clears the filter, gates input samples into it under a valid/ready handshake, and suppresses the warm-up transient. It forwards settled filter outputs downstream through a 2-entry output buffer with backpressure, and sits between the ADC sample stream and the peak/energy readout logic.

---
 rtl/trap_filter_ctrl.sv | 173 +++++++++++++++++
 tb/tb_trap_filter_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_filter_ctrl.sv
`default_nettype none
// trap_filter_ctrl: configuration, warm-up gating and 2-deep output buffering
// for the trapezoidal shaping filter.  Rev 1.0
module trap_filter_ctrl #(
   parameter int N       = 16,
   parameter int PW      = 5,
   parameter int FLT_LAT = 5,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_addr,
   input  logic [PW-1:0] cfg_wdata,
   output logic          cfg_err,
   output logic          busy,
   input  logic [N-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          flt_en,
   output logic          flt_clr,
   output logic [N-1:0]  flt_din,
   output logic [PW-1:0] flt_k,
   output logic [PW-1:0] flt_l,
   output logic [PW-1:0] flt_m1,
   output logic [PW-1:0] flt_m2,
   input  logic [N-1:0]  flt_dout,
   output logic [N-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLUSH  = 2'd1,
      S_WARMUP = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   localparam logic [PW+1:0] c_lat     = (PW+2)'(FLT_LAT);
   localparam logic [CW-1:0] c_cnt_max = '1;

   state_t         r_state, w_state_nxt;
   logic [PW-1:0]  r_k, r_l, r_m1, r_m2;
   logic           r_cfg_err;
   logic [CW-1:0]  r_cnt;
   logic           r_cap, r_cap_push;
   logic [N-1:0]   r_mem [2];
   logic           r_wr_ptr, r_rd_ptr;
   logic [1:0]     r_count;

   logic [PW+1:0]  w_t;
   logic           w_t_too_big;
   logic           w_ctrl, w_start, w_stop;
   logic           w_par_we, w_par_bad, w_par_ok, w_err;
   logic           w_in_ready, w_accept, w_push, w_pop;
   logic [CW-1:0]  w_cnt_inc;

   assign w_t         = {2'b00, r_k} + {2'b00, r_l} + c_lat;
   assign w_t_too_big = 32'(w_t) > 32'(c_cnt_max);

   assign w_ctrl   = cfg_we && (cfg_addr == 3'd4);
   assign w_stop   = w_ctrl && cfg_wdata[1];
   assign w_start  = w_ctrl && cfg_wdata[0] && !cfg_wdata[1];
   assign w_par_we = cfg_we && (cfg_addr < 3'd4);

   // l must never exceed k, whichever of the two is being rewritten
   assign w_par_bad = w_par_we &&
                      ((r_state != S_IDLE) ||
                       ((cfg_addr == 3'd0) && ((cfg_wdata == '0) || (r_l > cfg_wdata))) ||
                       ((cfg_addr == 3'd1) && (cfg_wdata > r_k)));
   assign w_par_ok  = w_par_we && !w_par_bad;
   assign w_err     = w_par_bad || (cfg_we && (cfg_addr > 3'd4)) ||
                      (w_start && (r_state == S_IDLE) && w_t_too_big);

   assign w_in_ready = ((r_state == S_WARMUP) || (r_state == S_RUN)) &&
                       ((r_count + {1'b0, r_cap}) < 2'd2);
   assign w_accept   = in_valid && w_in_ready;
   assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
   assign w_push     = r_cap_push;
   assign w_pop      = (r_count != 2'd0) && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start && !w_t_too_big) w_state_nxt = S_FLUSH;
         S_FLUSH:  w_state_nxt = w_stop ? S_IDLE : S_WARMUP;
         S_WARMUP: begin
            if (w_stop)
               w_state_nxt = S_IDLE;
            else if (w_accept && (32'(w_cnt_inc) == 32'(w_t)))
               w_state_nxt = S_RUN;
         end
         S_RUN:    if (w_stop) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cfg_err <= 1'b0;
         r_k       <= PW'(13);
         r_l       <= PW'(6);
         r_m1      <= PW'(16);
         r_m2      <= PW'(1);
      end else begin
         r_state   <= w_state_nxt;
         r_cfg_err <= w_err;
         if (w_par_ok) begin
            case (cfg_addr)
               3'd0:    r_k  <= cfg_wdata;
               3'd1:    r_l  <= cfg_wdata;
               3'd2:    r_m1 <= cfg_wdata;
               default: r_m2 <= cfg_wdata;
            endcase
         end
      end
   end

   // a sample's response appears on flt_dout one edge after it is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_cap      <= 1'b0;
         r_cap_push <= 1'b0;
      end else begin
         r_cap      <= w_accept;
         r_cap_push <= w_accept && (r_state == S_RUN);
         if (r_state == S_FLUSH)
            r_cnt <= '0;
         else if ((r_state == S_WARMUP) && w_accept)
            r_cnt <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= flt_dout;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign cfg_err   = r_cfg_err;
   assign busy      = (r_state != S_IDLE);
   assign in_ready  = w_in_ready;
   assign flt_en    = w_accept;
   assign flt_clr   = (r_state == S_FLUSH);
   assign flt_din   = in_data;
   assign flt_k     = r_k;
   assign flt_l     = r_l;
   assign flt_m1    = r_m1;
   assign flt_m2    = r_m2;
   assign out_data  = r_mem[r_rd_ptr];
   assign out_valid = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_trap_filter_ctrl.sv
`default_nettype none
// tb_trap_filter_ctrl: randomized self-checking bench with a queue-based model
// of warm-up suppression and in-order delivery.  Rev 1.0
module tb_trap_filter_ctrl;
   localparam int N       = 16;
   localparam int PW      = 5;
   localparam int FLT_LAT = 5;
   localparam int CW      = 8;
   localparam int T       = 13 + 6 + FLT_LAT;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_addr = '0;
   logic [PW-1:0] cfg_wdata = '0;
   logic          cfg_err, busy, in_ready, flt_en, flt_clr, out_valid;
   logic [N-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  flt_din, out_data;
   logic [N-1:0]  flt_dout = '0;
   logic [PW-1:0] flt_k, flt_l, flt_m1, flt_m2;
   logic          out_ready = 1'b0;

   int            n_vec = 0;
   int            n_err = 0;
   int            clr_cycles = 0;
   logic [N-1:0]  acc_q[$];
   logic [N-1:0]  pop_q[$];

   trap_filter_ctrl #(.N(N), .PW(PW), .FLT_LAT(FLT_LAT), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
      .busy(busy),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flt_en(flt_en), .flt_clr(flt_clr), .flt_din(flt_din),
      .flt_k(flt_k), .flt_l(flt_l), .flt_m1(flt_m1), .flt_m2(flt_m2),
      .flt_dout(flt_dout),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] resp(input logic [N-1:0] x);
      return x ^ 16'h5A3C;
   endfunction

   // stand-in filter: response to the accepted sample is visible one edge later
   always @(posedge clk or negedge reset) begin
      if (!reset)        flt_dout <= '0;
      else if (flt_clr)  flt_dout <= '0;
      else if (flt_en)   flt_dout <= resp(flt_din);
   end

   always @(negedge clk) begin
      if (in_valid && in_ready)   acc_q.push_back(in_data);
      if (out_valid && out_ready) pop_q.push_back(out_data);
      if (flt_clr)                clr_cycles++;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [PW-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic clear_model();
      acc_q.delete(); pop_q.delete(); clr_cycles = 0;
   endtask

   task automatic stream(input int target, input int p_valid, input int p_ready, input int max_cyc);
      int cyc = 0;
      while (acc_q.size() < target && cyc < max_cyc) begin
         in_valid  = (int'($urandom_range(99, 0)) < p_valid);
         in_data   = N'($urandom);
         out_ready = (int'($urandom_range(99, 0)) < p_ready);
         step();
         cyc++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (acc_q.size() != target) begin
         n_err++;
         $display("FAIL stream_timeout: accepted %0d required %0d", acc_q.size(), target);
      end
   endtask

   task automatic drain(input int cycles);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      #12;
      n_vec++;
      if ({flt_k, flt_l, flt_m1, flt_m2} !== {5'd13, 5'd6, 5'd16, 5'd1}) begin
         n_err++;
         $display("FAIL reset_params: got %0d/%0d/%0d/%0d required 13/6/16/1", flt_k, flt_l, flt_m1, flt_m2);
      end
      n_vec++;
      if ({busy, in_ready, flt_en, flt_clr, cfg_err, out_valid} !== 6'b0 || out_data !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got flags %b data %h required 000000 / 0000",
                  {busy, in_ready, flt_en, flt_clr, cfg_err, out_valid}, out_data);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      step();
   endtask

   task automatic test_config();
      cfg_write(3'd1, 5'd14);
      n_vec++;
      if (cfg_err !== 1'b1 || flt_l !== 5'd6) begin
         n_err++;
         $display("FAIL cfg_l_gt_k: err %b l %0d required err 1 l 6", cfg_err, flt_l);
      end
      step();
      n_vec++;
      if (cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_err_width: err %b required 0 one cycle later", cfg_err);
      end
      cfg_write(3'd0, 5'd0);
      n_vec++;
      if (cfg_err !== 1'b1 || flt_k !== 5'd13) begin
         n_err++;
         $display("FAIL cfg_k_zero: err %b k %0d required err 1 k 13", cfg_err, flt_k);
      end
      cfg_write(3'd0, 5'd5);
      n_vec++;
      if (cfg_err !== 1'b1 || flt_k !== 5'd13) begin
         n_err++;
         $display("FAIL cfg_k_lt_l: err %b k %0d required err 1 k 13", cfg_err, flt_k);
      end
      cfg_write(3'd6, 5'd3);
      n_vec++;
      if (cfg_err !== 1'b1) begin
         n_err++;
         $display("FAIL cfg_bad_addr: err %b required 1", cfg_err);
      end
      cfg_write(3'd2, 5'd9);
      n_vec++;
      if (cfg_err !== 1'b0 || flt_m1 !== 5'd9) begin
         n_err++;
         $display("FAIL cfg_m1_ok: err %b m1 %0d required err 0 m1 9", cfg_err, flt_m1);
      end
      cfg_write(3'd4, 5'd3);
      n_vec++;
      if (busy !== 1'b0 || cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_start_stop: busy %b err %b required 0 0", busy, cfg_err);
      end
   endtask

   task automatic test_warmup();
      clear_model();
      cfg_write(3'd4, 5'd1);
      n_vec++;
      if (busy !== 1'b1 || flt_clr !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL flush_state: busy %b clr %b ready %b required 1 1 0", busy, flt_clr, in_ready);
      end
      step();
      n_vec++;
      if (flt_clr !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL warmup_entry: clr %b ready %b required 0 1", flt_clr, in_ready);
      end
      stream(40, 70, 100, 400);
      drain(6);
      n_vec++;
      if (clr_cycles != 1 || pop_q.size() != 40 - T) begin
         n_err++;
         $display("FAIL warmup_count: clr %0d words %0d required 1 %0d", clr_cycles, pop_q.size(), 40 - T);
      end
      for (int j = 0; j < pop_q.size(); j++) begin
         n_vec++;
         if (j + T >= acc_q.size() || pop_q[j] !== resp(acc_q[j + T])) begin
            n_err++;
            $display("FAIL warmup_word[%0d]: got %h required response to sample %0d", j, pop_q[j], j + T + 1);
         end
      end
   endtask

   task automatic test_cfg_busy();
      cfg_write(3'd0, 5'd8);
      n_vec++;
      if (cfg_err !== 1'b1 || flt_k !== 5'd13) begin
         n_err++;
         $display("FAIL cfg_in_run: err %b k %0d required err 1 k 13", cfg_err, flt_k);
      end
      cfg_write(3'd4, 5'd1);
      n_vec++;
      if (cfg_err !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL start_while_busy: err %b busy %b required 0 1", cfg_err, busy);
      end
   endtask

   task automatic test_backpressure();
      clear_model();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = N'($urandom);
         step();
      end
      in_valid = 1'b0;
      n_vec++;
      if (acc_q.size() != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_hold: accepted %0d ready %b valid %b required 2 0 1", acc_q.size(), in_ready, out_valid);
      end
      drain(6);
      clear_model();
      stream(150, 60, 50, 3000);
      drain(8);
      n_vec++;
      if (pop_q.size() != acc_q.size()) begin
         n_err++;
         $display("FAIL bp_count: words %0d required %0d", pop_q.size(), acc_q.size());
      end
      for (int j = 0; j < pop_q.size(); j++) begin
         n_vec++;
         if (j >= acc_q.size() || pop_q[j] !== resp(acc_q[j])) begin
            n_err++;
            $display("FAIL bp_word[%0d]: got %h required response to accepted sample %0d", j, pop_q[j], j);
         end
      end
   endtask

   task automatic test_stop();
      clear_model();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = N'($urandom);
         step();
      end
      in_valid = 1'b0;
      cfg_write(3'd4, 5'd2);
      n_vec++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL stop_state: busy %b ready %b valid %b required 0 0 1", busy, in_ready, out_valid);
      end
      drain(6);
      n_vec++;
      if (pop_q.size() != 2 || acc_q.size() != 2 ||
          pop_q[0] !== resp(acc_q[0]) || pop_q[1] !== resp(acc_q[1])) begin
         n_err++;
         $display("FAIL stop_drain: words %0d accepted %0d required 2 matching responses", pop_q.size(), acc_q.size());
      end
   endtask

   task automatic test_reset_mid_run();
      clear_model();
      cfg_write(3'd4, 5'd1);
      step();
      stream(30, 100, 100, 200);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = N'($urandom);
         step();
      end
      #3;
      reset = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_async: valid %b busy %b ready %b required 0 0 0", out_valid, busy, in_ready);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      step();
      n_vec++;
      if (busy !== 1'b0 || flt_m1 !== 5'd16) begin
         n_err++;
         $display("FAIL reset_recover: busy %b m1 %0d required 0 16", busy, flt_m1);
      end
      clear_model();
      cfg_write(3'd4, 5'd1);
      step();
      stream(30, 80, 100, 300);
      drain(6);
      n_vec++;
      if (pop_q.size() != 30 - T || acc_q.size() != 30 || pop_q[0] !== resp(acc_q[T])) begin
         n_err++;
         $display("FAIL rewarm: words %0d required %0d, first word %h required response to sample %0d",
                  pop_q.size(), 30 - T, pop_q.size() > 0 ? pop_q[0] : 16'h0, T + 1);
      end
   endtask

   initial begin
      test_reset();
      test_config();
      test_warmup();
      test_cfg_busy();
      test_backpressure();
      test_stop();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
